// File: rtl/rrf.sv
// ============================================================================
// rrf : rename register file, tag-indexed speculative results with valid bits
// Optional same-cycle writeback bypass on read ports: RRF_BYPASS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module rrf #(
  parameter int RRF_NUM  = 64,
  parameter int RRF_SEL  = 6,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RRF_SEL-1:0]  rs1_rrftag_i,
  input  logic [RRF_SEL-1:0]  rs2_rrftag_i,
  output logic [DATA_LEN-1:0] rs1_rrfdata_o,
  output logic [DATA_LEN-1:0] rs2_rrfdata_o,
  output logic                rs1_rrfvalid_o,
  output logic                rs2_rrfvalid_o,
  input  logic                forward_rrf_we_i,
  input  logic [RRF_SEL-1:0]  forward_rrftag_i,
  input  logic [DATA_LEN-1:0] forward_rrfdata_i,
  input  logic                allocate_rrf_en_i,
  input  logic [RRF_SEL-1:0]  allocate_rrftag_i,
  input  logic [RRF_SEL-1:0]  completed_dst_rrftag_i,
  output logic [DATA_LEN-1:0] data_to_arfdata_o
);

  logic [DATA_LEN-1:0] data_q [RRF_NUM];
  logic [RRF_NUM-1:0]  valid_q;
  logic [RRF_NUM-1:0]  valid_d;

  // Allocate is applied after writeback so it wins a same-tag conflict.
  always_comb begin
    valid_d = valid_q;
    if (forward_rrf_we_i)  valid_d[forward_rrftag_i]  = 1'b1;
    if (allocate_rrf_en_i) valid_d[allocate_rrftag_i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RRF_NUM; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      if (forward_rrf_we_i) data_q[forward_rrftag_i] <= forward_rrfdata_i;
      valid_q <= valid_d;
    end
  end

`ifdef RRF_BYPASS_EN
  logic rs1_hit, rs2_hit, cmt_hit;

  assign rs1_hit = forward_rrf_we_i && (rs1_rrftag_i == forward_rrftag_i);
  assign rs2_hit = forward_rrf_we_i && (rs2_rrftag_i == forward_rrftag_i);
  assign cmt_hit = forward_rrf_we_i && (completed_dst_rrftag_i == forward_rrftag_i);

  assign rs1_rrfdata_o     = rs1_hit ? forward_rrfdata_i : data_q[rs1_rrftag_i];
  assign rs2_rrfdata_o     = rs2_hit ? forward_rrfdata_i : data_q[rs2_rrftag_i];
  assign rs1_rrfvalid_o    = rs1_hit | valid_q[rs1_rrftag_i];
  assign rs2_rrfvalid_o    = rs2_hit | valid_q[rs2_rrftag_i];
  assign data_to_arfdata_o = cmt_hit ? forward_rrfdata_i : data_q[completed_dst_rrftag_i];
`else
  assign rs1_rrfdata_o     = data_q[rs1_rrftag_i];
  assign rs2_rrfdata_o     = data_q[rs2_rrftag_i];
  assign rs1_rrfvalid_o    = valid_q[rs1_rrftag_i];
  assign rs2_rrfvalid_o    = valid_q[rs2_rrftag_i];
  assign data_to_arfdata_o = data_q[completed_dst_rrftag_i];
`endif

endmodule

`default_nettype wire

// File: tb/tb_rrf.sv
// ============================================================================
// tb_rrf : directed table-driven bench for the rename register file
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rrf;

  localparam int RRF_NUM  = 64;
  localparam int RRF_SEL  = 6;
  localparam int DATA_LEN = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [RRF_SEL-1:0]  rs1_rrftag_i, rs2_rrftag_i, completed_dst_rrftag_i;
  logic [DATA_LEN-1:0] rs1_rrfdata_o, rs2_rrfdata_o, data_to_arfdata_o;
  logic                rs1_rrfvalid_o, rs2_rrfvalid_o;
  logic                forward_rrf_we_i;
  logic [RRF_SEL-1:0]  forward_rrftag_i;
  logic [DATA_LEN-1:0] forward_rrfdata_i;
  logic                allocate_rrf_en_i;
  logic [RRF_SEL-1:0]  allocate_rrftag_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rrf #(.RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rs1_rrftag_i           (rs1_rrftag_i),
    .rs2_rrftag_i           (rs2_rrftag_i),
    .rs1_rrfdata_o          (rs1_rrfdata_o),
    .rs2_rrfdata_o          (rs2_rrfdata_o),
    .rs1_rrfvalid_o         (rs1_rrfvalid_o),
    .rs2_rrfvalid_o         (rs2_rrfvalid_o),
    .forward_rrf_we_i       (forward_rrf_we_i),
    .forward_rrftag_i       (forward_rrftag_i),
    .forward_rrfdata_i      (forward_rrfdata_i),
    .allocate_rrf_en_i      (allocate_rrf_en_i),
    .allocate_rrftag_i      (allocate_rrftag_i),
    .completed_dst_rrftag_i (completed_dst_rrftag_i),
    .data_to_arfdata_o      (data_to_arfdata_o)
  );

  typedef struct {
    string               name;
    logic                rst;
    logic                we;
    logic [RRF_SEL-1:0]  wtag;
    logic [DATA_LEN-1:0] wdata;
    logic                al;
    logic [RRF_SEL-1:0]  atag;
    logic [RRF_SEL-1:0]  t1, t2, tc;
    logic [DATA_LEN-1:0] e_d1, e_d2, e_dc;
    logic                e_v1, e_v2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [DATA_LEN-1:0] act,
                       input logic [DATA_LEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name,
                           input logic [DATA_LEN-1:0] d1, input logic v1,
                           input logic [DATA_LEN-1:0] d2, input logic v2,
                           input logic [DATA_LEN-1:0] dc);
    check({name, ".rs1_data"}, rs1_rrfdata_o, d1);
    check({name, ".rs1_valid"}, {31'b0, rs1_rrfvalid_o}, {31'b0, v1});
    check({name, ".rs2_data"}, rs2_rrfdata_o, d2);
    check({name, ".rs2_valid"}, {31'b0, rs2_rrfvalid_o}, {31'b0, v2});
    check({name, ".arf_data"}, data_to_arfdata_o, dc);
  endtask

  task automatic idle();
    reset = 1'b0; forward_rrf_we_i = 1'b0; allocate_rrf_en_i = 1'b0;
  endtask

  // Drive one edge's worth of activity, then drop enables so the reads
  // observe only the stored state.
  task automatic step(input logic rst, input logic we, input logic [RRF_SEL-1:0] wtag,
                      input logic [DATA_LEN-1:0] wdata, input logic al,
                      input logic [RRF_SEL-1:0] atag);
    reset = rst; forward_rrf_we_i = we; forward_rrftag_i = wtag;
    forward_rrfdata_i = wdata; allocate_rrf_en_i = al; allocate_rrftag_i = atag;
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  task automatic reads(input logic [RRF_SEL-1:0] t1, input logic [RRF_SEL-1:0] t2,
                       input logic [RRF_SEL-1:0] tc);
    rs1_rrftag_i = t1; rs2_rrftag_i = t2; completed_dst_rrftag_i = tc;
  endtask

  initial begin
    //           name       rst we wtag wdata          al atag t1  t2  tc  e_d1          e_d2          e_dc          e_v1 e_v2
    vecs[0] = '{"reset",    1, 0, 0,  32'h0,         0, 0,  0,  63, 0,  32'h0,        32'h0,        32'h0,        0, 0};
    vecs[1] = '{"wr_alloc", 0, 1, 0,  32'h1,         1, 1,  0,  1,  0,  32'h1,        32'h0,        32'h1,        1, 0};
    vecs[2] = '{"alloc5",   0, 0, 0,  32'h0,         1, 5,  5,  5,  5,  32'h0,        32'h0,        32'h0,        0, 0};
    vecs[3] = '{"wr5",      0, 1, 5,  32'hDEADBEEF,  0, 0,  5,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
    vecs[4] = '{"conflict7",0, 1, 7,  32'h1234,      1, 7,  7,  7,  7,  32'h1234,     32'h1234,     32'h1234,     0, 0};
    vecs[5] = '{"hold",     0, 0, 0,  32'h0,         0, 0,  0,  7,  1,  32'h1,        32'h1234,     32'h0,        1, 0};
    vecs[6] = '{"top_tags", 0, 1, 63, 32'hFFFFFFFF,  1, 62, 63, 62, 63, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1, 0};
    vecs[7] = '{"wr62",     0, 1, 62, 32'h55,        0, 0,  62, 63, 62, 32'h55,       32'hFFFFFFFF, 32'h55,       1, 1};
    vecs[8] = '{"indep",    0, 1, 0,  32'h2,         1, 63, 0,  63, 0,  32'h2,        32'hFFFFFFFF, 32'h2,        1, 0};
    vecs[9] = '{"rst_prio", 1, 1, 0,  32'h9,         0, 0,  0,  63, 5,  32'h0,        32'h0,        32'h0,        0, 0};

    idle();
    forward_rrftag_i = '0; forward_rrfdata_i = '0; allocate_rrftag_i = '0;
    reads(0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      reads(vecs[i].t1, vecs[i].t2, vecs[i].tc);
      step(vecs[i].rst, vecs[i].we, vecs[i].wtag, vecs[i].wdata, vecs[i].al, vecs[i].atag);
      check_all(vecs[i].name, vecs[i].e_d1, vecs[i].e_v1, vecs[i].e_d2, vecs[i].e_v2, vecs[i].e_dc);
    end

    // Same-cycle read of a tag under writeback (state was just reset).
    reads(3, 3, 3);
    reset = 1'b0; forward_rrf_we_i = 1'b1; forward_rrftag_i = 3;
    forward_rrfdata_i = 32'hA5; allocate_rrf_en_i = 1'b0;
    #1;
`ifdef RRF_BYPASS_EN
    check_all("samecyc_pre", 32'hA5, 1'b1, 32'hA5, 1'b1, 32'hA5);
`else
    check_all("samecyc_pre", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
`endif
    @(posedge clk);
    #1 idle();
    #1 check_all("samecyc_post", 32'hA5, 1'b1, 32'hA5, 1'b1, 32'hA5);

    // Mid-run reset after filling tags 0..3.
    for (int t = 0; t < 4; t++) step(0, 1, t[RRF_SEL-1:0], 32'h100 + t, 0, 0);
    reads(2, 3, 0);
    #1 check_all("filled", 32'h102, 1'b1, 32'h103, 1'b1, 32'h100);
    step(1, 0, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      reads(t[RRF_SEL-1:0], t[RRF_SEL-1:0], t[RRF_SEL-1:0]);
      #1 check_all($sformatf("midrst_tag%0d", t), 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rrf.md
# rrf

Rename register file (RRF) of the out-of-order core. It holds speculative results in physical rename entries between execution and commit. Execution units write results here by RRF tag. Dispatch reads operand data and valid bits per tag, and commit reads the completed entry's data for transfer into the architectural register file (ARF). Each entry has one valid bit that allocation clears and writeback sets.

## Interface
Parameters:
- RRF_NUM, 64, number of rename entries
- RRF_SEL, 6, tag width (log2 RRF_NUM)
- DATA_LEN, 32, data width per entry

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rs1_rrftag_i  in  RRF_SEL  source-1 read tag
- rs2_rrftag_i  in  RRF_SEL  source-2 read tag
- rs1_rrfdata_o  out  DATA_LEN  data of entry rs1_rrftag_i
- rs2_rrfdata_o  out  DATA_LEN  data of entry rs2_rrftag_i
- rs1_rrfvalid_o  out  1  valid bit of entry rs1_rrftag_i
- rs2_rrfvalid_o  out  1  valid bit of entry rs2_rrftag_i
- forward_rrf_we_i  in  1  writeback enable
- forward_rrftag_i  in  RRF_SEL  writeback tag
- forward_rrfdata_i  in  DATA_LEN  writeback data
- allocate_rrf_en_i  in  1  allocate enable (dispatch)
- allocate_rrftag_i  in  RRF_SEL  tag being allocated
- completed_dst_rrftag_i  in  RRF_SEL  tag of the committing instruction
- data_to_arfdata_o  out  DATA_LEN  data of entry completed_dst_rrftag_i, to the ARF

## Operation
- Storage: RRF_NUM x DATA_LEN data array and an RRF_NUM-bit valid vector.
- Writeback: when forward_rrf_we_i=1, the edge writes data[forward_rrftag_i] <= forward_rrfdata_i and sets valid[forward_rrftag_i] <= 1.
- Allocate: when allocate_rrf_en_i=1, the edge clears valid[allocate_rrftag_i] <= 0. Data is untouched.
- Same-tag conflict: if writeback and allocate target the same tag in one cycle, the data is written and the valid bit ends at 0. Allocate wins for valid.
- Different tags: writeback and allocate apply independently in the same cycle.
- Reads: rs1, rs2 and commit ports are combinational array lookups. Any tag, including duplicate tags, may be read on all ports at once.
- No tag range checking is done. All tags index the full 2^RRF_SEL space, with RRF_NUM = 2^RRF_SEL.
- Reset: the edge with reset=1 clears every valid bit and every data word to 0. Reset has priority over writeback and allocate in that cycle.

## Timing
- Write latency is one cycle. Data written at edge N is visible on the read ports after edge N.
- Read latency is zero (combinational from tag and state).
- Without RRF_BYPASS_EN, a read of a tag being written in the same cycle returns the old data and old valid.
- After reset, every output that is a function of state is 0:
  - rs*_rrfvalid_o = 0
  - rs*_rrfdata_o = 0
  - data_to_arfdata_o = 0
- No handshake: enables are single-cycle qualifiers and there is no back-pressure.
- Reset asserted mid-operation discards all pending entries on that edge.

## Configuration
- RRF_BYPASS_EN defined:
  - When forward_rrf_we_i=1 and a read tag (rs1, rs2 or completed_dst) equals forward_rrftag_i, that port returns forward_rrfdata_i combinationally in the same cycle.
  - rs1/rs2 valid outputs return 1 for such a match.
  - An allocate to the same tag in the same cycle does not suppress the bypass of the current read.
- RRF_BYPASS_EN undefined: reads return stored state only, as in Timing.

## Test plan
- Reset: hold reset=1 for one edge, then read tags 0 and 63 -> both valid=0, data=0, data_to_arfdata_o=0.
- Write + allocate in one cycle: we=1, tag=0, data=1 and allocate tag=1 on one edge -> rs1 tag 0 gives data 1, valid 1; rs2 tag 1 gives valid 0.
- Allocate then writeback:
  - Allocate tag 5 -> valid 0.
  - Next cycle write tag 5 with 0xDEADBEEF -> rs1, rs2 and commit reads of tag 5 show 0xDEADBEEF, valid 1.
- Same-tag conflict: write tag 7 with 0x1234 and allocate tag 7 on the same edge -> valid 0; data_to_arfdata_o with completed tag 7 = 0x1234.
- Same-cycle read of a tag being written (tag 3, data 0xA5):
  - Without RRF_BYPASS_EN: old value 0 and valid 0 before the edge, 0xA5 after.
  - With RRF_BYPASS_EN: 0xA5 and valid 1 immediately.
- Mid-run reset: fill tags 0 to 3 with valid data, assert reset for one edge -> all valid bits are 0 and all reads return 0.
